// File: rtl/demux1to2_stream.sv
// Registered 1-to-2 valid/ready stream demultiplexer: packets are steered by
// in_sel on their first beat. Optional per-channel beat counters: DEMUX1TO2_STREAM_COUNT_EN.
module demux1to2_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_last,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_last,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic              busy
`ifdef DEMUX1TO2_STREAM_COUNT_EN
    ,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE0 = 2'd1,
        ROUTE1 = 2'd2
    } state_t;

    if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
        $error("DATA_W and CNT_W must both be at least 1");
    end

    state_t            r_state;
    state_t            w_state_next;
    logic              w_target;
    logic              w_accept;

    logic [1:0]        r_valid;
    logic [1:0]        r_last;
    logic [DATA_W-1:0] r_data [2];
    logic [1:0]        w_out_ready;
    logic [1:0]        w_load;
    logic [1:0]        w_handshake;

    assign w_out_ready = {out1_ready, out0_ready};

    // The locked channel wins over in_sel for every beat after the first.
    always_comb begin
        // NOTE: default first so every path assigns w_target; no latch is inferred.
        w_target = in_sel;
        case (r_state)
            ROUTE0:  w_target = 1'b0;
            ROUTE1:  w_target = 1'b1;
            default: w_target = in_sel;
        endcase
    end

    // Readiness looks only at the target's output slot, never at in_valid.
    assign in_ready = !reset && (!r_valid[w_target] || w_out_ready[w_target]);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !in_last)
                    w_state_next = in_sel ? ROUTE1 : ROUTE0;
            end
            ROUTE0, ROUTE1: begin
                if (w_accept && in_last)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    assign busy = (r_state != IDLE);

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        assign w_load[ch]      = w_accept && (w_target == ch[0]);
        assign w_handshake[ch] = r_valid[ch] && w_out_ready[ch];

        // A load wins over a handshake, so back-to-back beats leave no bubble.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_valid[ch] <= 1'b0;
                r_last[ch]  <= 1'b0;
                r_data[ch]  <= '0;
            end else if (w_load[ch]) begin
                r_valid[ch] <= 1'b1;
                r_last[ch]  <= in_last;
                r_data[ch]  <= in_data;
            end else if (w_handshake[ch]) begin
                r_valid[ch] <= 1'b0;
            end
        end
    end

    assign out0_valid = r_valid[0];
    assign out0_last  = r_last[0];
    assign out0_data  = r_data[0];
    assign out1_valid = r_valid[1];
    assign out1_last  = r_last[1];
    assign out1_data  = r_data[1];

`ifdef DEMUX1TO2_STREAM_COUNT_EN
    logic [CNT_W-1:0] r_cnt [2];

    // Counters wrap naturally at 2^CNT_W.
    for (genvar ch = 0; ch < 2; ch++) begin : g_cnt
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                r_cnt[ch] <= '0;
            else if (w_handshake[ch])
                r_cnt[ch] <= r_cnt[ch] + CNT_W'(1);
        end
    end

    assign cnt0 = r_cnt[0];
    assign cnt1 = r_cnt[1];
`endif

endmodule
